// File: rtl/display_pkg.sv
// Shared constants for the result display: 7-segment glyph table, blank and
// 'F' glyphs, the state-error code, and the one-hot state index encoder.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [3:0] STATE_ERR = 4'hE;

  // Hex glyphs 0-F; b and d are lowercase shapes.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // One-hot state flags to index 0-5. Anything that is not exactly one-hot
  // shows up as the error code.
  function automatic logic [3:0] state_index(input logic [5:0] s);
    logic [3:0] idx;
    case (s)
      6'b000001: idx = 4'd0;
      6'b000010: idx = 4'd1;
      6'b000100: idx = 4'd2;
      6'b001000: idx = 4'd3;
      6'b010000: idx = 4'd4;
      6'b100000: idx = 4'd5;
      default:   idx = STATE_ERR;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low 7-segment decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/result_display_driver.sv
// Multiplexed 4-digit common-anode display driver for the toy processor.
// Digits 1:0 show the result byte in hex, digit 2 the state index, digit 3 a
// sticky blinking overflow 'F'. DP on digit 3 tracks the live overflow flag.
// All outputs are registered; data reaches the pins two cycles after input.
module result_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       OVF_IN,
  input  logic [5:0] STATE_IN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DW = $clog2(NUM_DIGITS);

  localparam logic [RW-1:0] RCNT_MAX  = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX   = DW'(NUM_DIGITS - 1);

  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;
  logic [5:0]    state_q, state_d;
  logic          ovf_sticky_q, ovf_sticky_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          rcnt_wrap;
  logic          frame_tick;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;

  // Capture, sticky overflow, and refresh/frame/blink counter next-state.
  always_comb begin
    data_d       = DATA_IN;
    ovf_d        = OVF_IN;
    state_d      = STATE_IN;
    ovf_sticky_d = ovf_sticky_q | ovf_q;

    rcnt_wrap  = (rcnt_q == RCNT_MAX);
    frame_tick = rcnt_wrap && (dig_q == DIG_MAX);

    rcnt_d  = rcnt_wrap ? '0 : rcnt_q + 1'b1;
    dig_d   = dig_q;
    frame_d = frame_q;
    blink_d = blink_q;

    if (rcnt_wrap) begin
      dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
    end
    if (frame_tick) begin
      if (frame_q == FRAME_MAX) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Digit-select mux feeding the single hex decoder.
  always_comb begin
    nib = 4'h0;
    case (dig_q)
      2'd0:    nib = data_q[3:0];
      2'd1:    nib = data_q[7:4];
      2'd2:    nib = state_index(state_q);
      default: nib = 4'h0;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib (nib),
    .seg (dec_seg)
  );

  // Output register inputs: one anode low, glyph per digit, DP on digit 3.
  always_comb begin
    an_d  = ~(4'b0001 << dig_q);
    seg_d = dec_seg;
    dp_d  = 1'b1;
    if (dig_q == DIG_MAX) begin
      seg_d = (ovf_sticky_q && blink_q) ? SEG_F : SEG_BLANK;
      dp_d  = ~ovf_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q       <= '0;
      ovf_q        <= 1'b0;
      state_q      <= '0;
      ovf_sticky_q <= 1'b0;
      rcnt_q       <= '0;
      dig_q        <= '0;
      frame_q      <= '0;
      blink_q      <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      data_q       <= data_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      ovf_sticky_q <= ovf_sticky_d;
      rcnt_q       <= rcnt_d;
      dig_q        <= dig_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with REFRESH_DIV=4, BLINK_DIV=2.
// cyc counts observed edges since RESET fell; the output seen after edge cyc
// reflects the scan position after cyc-1 counting edges, so digit d is shown
// on cyc 4d+1..4d+4 of each 16-cycle frame and blink is high on cyc 33..64.
module tb_result_display_driver;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       ovf_in;
  logic [5:0] state_in;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int check_cnt = 0;
  int err_cnt   = 0;
  int cyc       = 0;

  // Expected glyphs (active-low {g,f,e,d,c,b,a}).
  localparam logic [6:0] G_0 = 7'h40;
  localparam logic [6:0] G_2 = 7'h24;
  localparam logic [6:0] G_3 = 7'h30;
  localparam logic [6:0] G_5 = 7'h12;
  localparam logic [6:0] G_C = 7'h46;
  localparam logic [6:0] G_E = 7'h06;
  localparam logic [6:0] G_F = 7'h0E;
  localparam logic [6:0] G_BLANK = 7'h7F;

  logic [3:0] an_tab [4];
  logic [6:0] seg_tab [4];

  result_display_driver #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (2)
  ) dut (
    .CLK      (clk),
    .RESET    (reset),
    .DATA_IN  (data_in),
    .OVF_IN   (ovf_in),
    .STATE_IN (state_in),
    .SEG      (seg),
    .DP       (dp),
    .AN       (an)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
    check_val({tag, "_an"}, {4'h0, an}, {4'h0, e_an});
    check_val({tag, "_seg"}, {1'b0, seg}, {1'b0, e_seg});
  endtask

  initial begin
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{G_C, G_3, G_2, G_BLANK};

    // Reset held for 3 cycles
    reset = 1'b1; data_in = 8'h00; ovf_in = 1'b0; state_in = 6'b000000;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_out("reset", 4'b1111, G_BLANK);
    check_val("reset_dp", {7'h0, dp}, 8'h01);

    // Release with data 0x3C and state S2
    data_in = 8'h3C; state_in = 6'b000100; reset = 1'b0; cyc = 0;
    tick();
    check_out("first_digit", 4'b1110, G_0);
    ovf_in = 1'b1;
    tick();
    check_out("data_lag2", 4'b1110, G_C);
    ovf_in = 1'b0;

    // Full first frame and start of the next
    for (int c = 3; c <= 17; c++) begin
      tick();
      check_out("scan", an_tab[((c - 1) / 4) % 4], seg_tab[((c - 1) / 4) % 4]);
      if (c == 14) check_val("dp_after_pulse", {7'h0, dp}, 8'h01);
    end

    // State error: no bits set
    state_in = 6'b000000;
    run_to(26);
    check_out("state_none", 4'b1011, G_E);
    state_in = 6'b100000;
    tick();
    check_out("state_lag", 4'b1011, G_E);
    tick();
    check_out("state_s5", 4'b1011, G_5);
    state_in = 6'b010010;
    run_to(30);
    check_out("ovf_blank_f2", 4'b0111, G_BLANK);
    run_to(42);
    check_out("state_multi", 4'b1011, G_E);
    run_to(46);
    check_out("ovf_f_on", 4'b0111, G_F);
    check_val("ovf_dp_off", {7'h0, dp}, 8'h01);
    run_to(62);
    check_out("ovf_f_on2", 4'b0111, G_F);
    data_in = 8'h00;

    // Live overflow drives DP on digit 3 (blink low again here)
    run_to(76);
    ovf_in = 1'b1;
    tick();
    check_val("dp_lag", {7'h0, dp}, 8'h01);
    check_out("ovf_blank_f5", 4'b0111, G_BLANK);
    tick();
    check_val("dp_live", {7'h0, dp}, 8'h00);
    run_to(80);
    check_val("dp_live_end", {7'h0, dp}, 8'h00);
    check_val("seg_blank_live", {1'b0, seg}, {1'b0, G_BLANK});
    ovf_in = 1'b0;
    tick();
    check_out("live_d0_old", 4'b1110, G_0);
    check_val("dp_digit0", {7'h0, dp}, 8'h01);

    // Live data update while digit 0 enabled
    data_in = 8'hFF;
    tick();
    check_out("live_lag1", 4'b1110, G_0);
    tick();
    check_out("live_update", 4'b1110, G_F);
    tick();
    check_val("live_an_hold", {4'h0, an}, 8'h0E);
    tick();
    check_out("live_d1", 4'b1101, G_F);

    // Mid-scan reset on digit 2 with sticky set; OVF_IN high during reset
    run_to(90);
    check_out("pre_reset", 4'b1011, G_E);
    reset = 1'b1; ovf_in = 1'b1;
    tick();
    check_out("mid_reset", 4'b1111, G_BLANK);
    check_val("mid_reset_dp", {7'h0, dp}, 8'h01);
    reset = 1'b0; ovf_in = 1'b0; cyc = 0;
    tick();
    check_out("restart_d0", 4'b1110, G_0);
    run_to(14);
    check_out("restart_d3", 4'b0111, G_BLANK);
    run_to(46);
    check_out("sticky_cleared", 4'b0111, G_BLANK);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
